// File: rtl/tmdb_trig_tx.sv
// Trigger-frame transmitter: queues flagged events with their BCID and sends 3-word frames.
// Latency: det edge to W0 is 2 cycles when idle; each word holds until tx_ready, and a full FIFO drops events.
module tmdb_trig_tx #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          BC_MAX     = 3563,
    parameter logic [15:0] IDLE_WORD  = 16'hBC50
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         det,
    input  logic signed [18:0] e6,
    input  logic signed [18:0] e56,
    input  logic               bcr,
    input  logic               tx_ready,
    output logic [15:0]        tx_data,
    output logic               tx_valid,
    output logic               tx_sof,
    output logic [11:0]        bcid,
    output logic [7:0]         drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [11:0] bc;
        logic [3:0]  det;
        logic [11:0] e6;
        logic [11:0] e56;
    } evt_t;

    typedef enum logic [1:0] {S_IDLE, S_W0, S_W1, S_W2} state_t;

    function automatic logic [11:0] sat(input logic signed [18:0] x);
        if (x[18])
            return 12'h000;
        else if (|x[17:12])
            return 12'hFFF;
        else
            return x[11:0];
    endfunction

    evt_t        mem [FIFO_DEPTH];
    evt_t        frame;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, wr_en, pop;
    state_t        state, state_n;

    assign full  = (count == (AW+1)'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign wr_en = (|det) && !full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bcid <= '0;
        else if (bcr)
            bcid <= '0;
        else if (bcid == 12'(BC_MAX))
            bcid <= '0;
        else
            bcid <= bcid + 12'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_cnt <= '0;
        else if ((|det) && full && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= '{bc: bcid, det: det, e6: sat(e6), e56: sat(e56)};
    end

    // Full is judged on pre-edge occupancy, so a same-cycle pop never admits an extra write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            frame <= '0;
        end else begin
            state <= state_n;
            if (pop)
                frame <= mem[rd_ptr];
        end
    end

    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        tx_valid = 1'b0;
        tx_sof   = 1'b0;
        tx_data  = IDLE_WORD;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_W0;
                end
            end
            S_W0: begin
                tx_valid = 1'b1;
                tx_sof   = 1'b1;
                tx_data  = {4'hA, frame.bc};
                if (tx_ready)
                    state_n = S_W1;
            end
            S_W1: begin
                tx_valid = 1'b1;
                tx_data  = {frame.det, frame.e6};
                if (tx_ready)
                    state_n = S_W2;
            end
            S_W2: begin
                tx_valid = 1'b1;
                tx_data  = {4'h5, frame.e56};
                if (tx_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_W0;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_tmdb_trig_tx.sv
// Directed bench for tmdb_trig_tx with a scoreboard of expected frame words.
module tb_tmdb_trig_tx;
    logic               clk;
    logic               rst;
    logic [3:0]         det;
    logic signed [18:0] e6;
    logic signed [18:0] e56;
    logic               bcr;
    logic               tx_ready;
    logic [15:0]        tx_data;
    logic               tx_valid;
    logic               tx_sof;
    logic [11:0]        bcid;
    logic [7:0]         drop_cnt;

    tmdb_trig_tx dut (
        .clk(clk), .rst(rst), .det(det), .e6(e6), .e56(e56), .bcr(bcr),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_sof(tx_sof), .bcid(bcid), .drop_cnt(drop_cnt)
    );

    int          checks = 0;
    int          passed = 0;
    logic [16:0] q[$];
    logic [11:0] tb_bc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference bunch counter.
    always @(posedge clk or posedge rst) begin
        if (rst)                 tb_bc <= 12'd0;
        else if (bcr)            tb_bc <= 12'd0;
        else if (tb_bc == 12'd3563) tb_bc <= 12'd0;
        else                     tb_bc <= tb_bc + 12'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] sat(input int x);
        if (x < 0) return 12'h000;
        if (x > 4095) return 12'hFFF;
        return x[11:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ev(input logic [3:0] d, input int a, input int b, input bit push);
        det = d;
        e6  = 19'(a);
        e56 = 19'(b);
        if (push) begin
            q.push_back({1'b1, 4'hA, tb_bc});
            q.push_back({1'b0, d, sat(a)});
            q.push_back({1'b0, 4'h5, sat(b)});
        end
    endtask

    task automatic pulse(input logic [3:0] d, input int a, input int b);
        drive_ev(d, a, b, 1'b1);
        step();
        det = 4'd0;
    endtask

    // Every accepted word is checked against the scoreboard.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            checks++;
            assert (q.size() > 0) passed++;
            else $error("FAIL extra_word: observed %0h expected no word", tx_data);
            if (q.size() > 0) chk("tx_word", {15'd0, tx_sof, tx_data}, {15'd0, q.pop_front()});
        end
    end

    initial begin
        int n;
        rst = 1'b1; det = 4'd0; e6 = '0; e56 = '0; bcr = 1'b0; tx_ready = 1'b0;
        repeat (3) step();
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_sof",   32'(tx_sof),   32'd0);
        chk("rst_data",  32'(tx_data),  32'hBC50);
        chk("rst_bcid",  32'(bcid),     32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b0;

        // Single event at bcid 10
        tx_ready = 1'b1;
        repeat (10) step();
        pulse(4'b0011, 300, 500);
        chk("lat_n1_valid", 32'(tx_valid), 32'd0);
        step();
        chk("w0_valid", 32'(tx_valid), 32'd1);
        chk("w0_sof",   32'(tx_sof),   32'd1);
        chk("w0_data",  32'(tx_data),  32'hA00A);
        step();
        chk("w1_data",  32'(tx_data),  32'h312C);
        chk("w1_sof",   32'(tx_sof),   32'd0);
        step();
        chk("w2_data",  32'(tx_data),  32'h51F4);
        step();
        chk("idle_valid", 32'(tx_valid), 32'd0);
        chk("idle_data",  32'(tx_data),  32'hBC50);

        // Saturation
        pulse(4'b1000, -5, 5000);
        step(); step();
        chk("sat_w1_low", 32'(tx_data[11:0]), 32'd0);
        step();
        chk("sat_w2", 32'(tx_data), 32'h5FFF);
        repeat (3) step();

        // Backpressure in W1
        pulse(4'b0001, 7, 9);
        step(); step();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(tx_valid), 32'd1);
            chk("bp_hold",  32'(tx_data),  32'h1007);
            step();
        end
        tx_ready = 1'b1;
        chk("bp_last_w1", 32'(tx_data), 32'h1007);
        step();
        chk("bp_w2", 32'(tx_data), 32'h5009);
        repeat (3) step();

        // Overflow: 1 in frame register, 4 queued, 2 dropped
        tx_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive_ev(4'b0010, i * 10 + 1, i, i < 5);
            step();
        end
        det = 4'd0;
        step();
        chk("ovf_drop", 32'(drop_cnt), 32'd2);
        tx_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (tx_valid) n++;
            step();
        end
        chk("ovf_b2b_cycles", 32'(n), 32'd15);
        chk("ovf_done_valid", 32'(tx_valid), 32'd0);

        // BCID wrap with an event in the wrap cycle
        n = 0;
        while (tb_bc != 12'd3563 && n < 5000) begin
            step();
            n++;
        end
        chk("bc_max", 32'(bcid), 32'd3563);
        drive_ev(4'b0100, 1, 2, 1'b1);
        step();
        det = 4'd0;
        chk("bc_wrap", 32'(bcid), 32'd0);
        repeat (6) step();
        n = 0;
        while (tb_bc != 12'd100 && n < 5000) begin
            step();
            n++;
        end
        chk("bc_100", 32'(bcid), 32'd100);
        bcr = 1'b1;
        step();
        bcr = 1'b0;
        chk("bcr_zero", 32'(bcid), 32'd0);

        // Reset during W1 with a second event queued
        drive_ev(4'b0001, 3, 4, 1'b1);
        step();
        drive_ev(4'b0010, 5, 6, 1'b0);
        step();
        det = 4'd0;
        step();
        chk("mid_w1_data", 32'(tx_data), 32'h1003);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_data",  32'(tx_data),  32'hBC50);
        chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
        q.delete();
        step(); step();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (tx_valid) n++;
            step();
        end
        chk("post_rst_quiet", 32'(n), 32'd0);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
